frv_interrupt_ctrl: RTL and testbench

//  Parametrised successor to the core interrupt unit: NSRC external lines, each edge- or level-

---
 rtl/frv_int_pkg.sv | 31 +++
 rtl/frv_interrupt_ctrl_if.sv | 20 ++
 rtl/frv_int_prio_enc.sv | 20 ++
 rtl/frv_interrupt_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_frv_interrupt_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/frv_int_pkg.sv
// frv_int_pkg: cause codes, FSM state and claim record shared by the interrupt controller.
package frv_int_pkg;

  localparam logic [5:0] CAUSE_MSI      = 6'd3;
  localparam logic [5:0] CAUSE_MTI      = 6'd7;
  localparam logic [5:0] CAUSE_EXT_BASE = 6'd16;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } state_e;

  typedef enum logic [1:0] {
    SRC_NMI,
    SRC_EXT,
    SRC_SW,
    SRC_TMR
  } src_kind_e;

  // Which source a pending trap belongs to, so the ack clears the right latch
  // even if NMI_CAUSE aliases another cause code.
  typedef struct packed {
    src_kind_e  kind;
    logic [4:0] id;
  } claim_t;

  function automatic logic [5:0] ext_cause(input logic [4:0] id);
    return CAUSE_EXT_BASE + {1'b0, id};
  endfunction

endpackage

// File: rtl/frv_interrupt_ctrl_if.sv
// frv_interrupt_ctrl_if: trap request/acknowledge handshake between the interrupt controller and WB.
interface frv_interrupt_ctrl_if;

  logic       int_trap_req;
  logic [5:0] int_trap_cause;
  logic       int_trap_ack;

  modport master (
    output int_trap_req,
    output int_trap_cause,
    input  int_trap_ack
  );

  modport slave (
    input  int_trap_req,
    input  int_trap_cause,
    output int_trap_ack
  );

endinterface

// File: rtl/frv_int_prio_enc.sv
// frv_int_prio_enc: combinational lowest-index-first encoder over NSRC request lines.
module frv_int_prio_enc #(
  parameter int NSRC = 16
) (
  input  logic [NSRC-1:0] req_i,
  output logic            valid_o,
  output logic [4:0]      id_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    id_o = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = 5'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/frv_interrupt_ctrl.sv
// frv_interrupt_ctrl: NMI / external / software / timer interrupt arbitration with a held trap request.
// Optional build macro FRV_INT_SYNC_EN adds a 2-flop input synchroniser (input-to-req latency 3).
module frv_interrupt_ctrl
  import frv_int_pkg::*;
#(
  parameter int              NSRC      = 16,
  parameter logic [NSRC-1:0] EDGE_MASK = '0,
  parameter logic [5:0]      NMI_CAUSE = 6'd0
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  mstatus_mie,
  input  logic                  mie_meie,
  input  logic                  mie_mtie,
  input  logic                  mie_msie,
  input  logic [NSRC-1:0]       ex_enable,
  input  logic                  nmi_pending,
  input  logic [NSRC-1:0]       ex_pending,
  input  logic                  ti_pending,
  input  logic                  sw_pending,
  output logic                  mip_meip,
  output logic                  mip_mtip,
  output logic                  mip_msip,
  frv_interrupt_ctrl_if.master  trap,
  output logic [4:0]            ex_claim_id
);

  logic            nmi_in, ti_in, sw_in;
  logic [NSRC-1:0] ex_in;

`ifdef FRV_INT_SYNC_EN
  logic [NSRC+2:0] meta_q, sync_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {nmi_pending, ti_pending, sw_pending, ex_pending};
      sync_q <= meta_q;
    end
  end

  assign {nmi_in, ti_in, sw_in, ex_in} = sync_q;
`else
  assign nmi_in = nmi_pending;
  assign ti_in  = ti_pending;
  assign sw_in  = sw_pending;
  assign ex_in  = ex_pending;
`endif

  state_e          state_q;
  logic            req_q;
  logic [5:0]      cause_q;
  claim_t          claim_q;
  logic [4:0]      claim_id_q;

  logic            nmi_prev_q, nmi_lat_q, nmi_lat_d, nmi_rise;
  logic [NSRC-1:0] ex_prev_q, ex_lat_q, ex_lat_d, ex_rise, ex_clr;
  logic [NSRC-1:0] ex_pend, ex_elig;
  logic            take;

  assign take     = (state_q == ST_REQ) && trap.int_trap_ack;
  assign ex_rise  = ex_in & ~ex_prev_q & EDGE_MASK;
  assign nmi_rise = nmi_in & ~nmi_prev_q;

  // A rise is visible to arbitration in the same cycle it is latched, giving 1-cycle latency.
  assign ex_pend  = (EDGE_MASK & (ex_lat_q | ex_rise)) | (~EDGE_MASK & ex_in);

  // Set wins over a same-cycle clear so a re-pulse during the ack is not lost.
  always_comb begin
    ex_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      ex_clr[i] = take && (claim_q.kind == SRC_EXT) && (claim_q.id == 5'(i));
    end
    ex_lat_d  = EDGE_MASK & (ex_rise | (ex_lat_q & ~ex_clr));
    nmi_lat_d = nmi_rise | (nmi_lat_q & ~(take && (claim_q.kind == SRC_NMI)));
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      nmi_prev_q <= 1'b0;
      nmi_lat_q  <= 1'b0;
      ex_prev_q  <= '0;
      ex_lat_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      nmi_prev_q <= nmi_in;
      nmi_lat_q  <= nmi_lat_d;
      ex_prev_q  <= ex_in;
      ex_lat_q   <= ex_lat_d;
    end
  end

  logic nmi_elig, sw_elig, tmr_elig, ex_valid, any_elig;
  logic [4:0] ex_id;

  assign ex_elig  = ex_pend & ex_enable & {NSRC{mie_meie & mstatus_mie}};
  assign nmi_elig = nmi_lat_q | nmi_rise;
  assign sw_elig  = sw_in & mie_msie & mstatus_mie;
  assign tmr_elig = ti_in & mie_mtie & mstatus_mie;
  assign any_elig = nmi_elig | ex_valid | sw_elig | tmr_elig;

  frv_int_prio_enc #(
    .NSRC (NSRC)
  ) u_prio (
    .req_i   (ex_elig),
    .valid_o (ex_valid),
    .id_o    (ex_id)
  );

  claim_t     win_claim;
  logic [5:0] win_cause;

  always_comb begin
    win_claim = '{kind: SRC_NMI, id: 5'd0};
    win_cause = NMI_CAUSE;
    if (nmi_elig) begin
      win_claim = '{kind: SRC_NMI, id: 5'd0};
      win_cause = NMI_CAUSE;
    end else if (ex_valid) begin
      win_claim = '{kind: SRC_EXT, id: ex_id};
      win_cause = ext_cause(ex_id);
    end else if (sw_elig) begin
      win_claim = '{kind: SRC_SW, id: 5'd0};
      win_cause = CAUSE_MSI;
    end else if (tmr_elig) begin
      win_claim = '{kind: SRC_TMR, id: 5'd0};
      win_cause = CAUSE_MTI;
    end
  end

  // Request is held without preemption until WB acks or MIE withdraws a maskable trap.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      cause_q    <= '0;
      claim_q    <= '{kind: SRC_NMI, id: 5'd0};
      claim_id_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            cause_q <= win_cause;
            claim_q <= win_claim;
          end
        end
        ST_REQ: begin
          if (trap.int_trap_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            if (claim_q.kind == SRC_EXT) claim_id_q <= claim_q.id;
          end else if (!mstatus_mie && (claim_q.kind != SRC_NMI)) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  logic meip_q, mtip_q, msip_q;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      meip_q <= 1'b0;
      mtip_q <= 1'b0;
      msip_q <= 1'b0;
    end else begin
      meip_q <= |(ex_pend & ex_enable);
      mtip_q <= ti_in;
      msip_q <= sw_in;
    end
  end

  assign trap.int_trap_req   = req_q;
  assign trap.int_trap_cause = cause_q;
  assign ex_claim_id         = claim_id_q;
  assign mip_meip            = meip_q;
  assign mip_mtip            = mtip_q;
  assign mip_msip            = msip_q;

endmodule

// File: tb/tb_frv_interrupt_ctrl.sv
// tb_frv_interrupt_ctrl: directed vectors with hand-computed expectations for frv_interrupt_ctrl.
module tb_frv_interrupt_ctrl;

  localparam int              NSRC      = 16;
  localparam logic [NSRC-1:0] EDGE_MASK = 16'h0220;  // sources 5 and 9 edge, rest level
`ifdef FRV_INT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic            g_clk = 1'b0;
  logic            g_resetn = 1'b0;
  logic            mstatus_mie = 1'b1, mie_meie = 1'b1, mie_mtie = 1'b1, mie_msie = 1'b1;
  logic [NSRC-1:0] ex_enable = '1;
  logic            nmi_pending = 1'b0, ti_pending = 1'b0, sw_pending = 1'b0;
  logic [NSRC-1:0] ex_pending = '0;
  logic            mip_meip, mip_mtip, mip_msip;
  logic [4:0]      ex_claim_id;

  frv_interrupt_ctrl_if trap_if ();

  frv_interrupt_ctrl #(
    .NSRC      (NSRC),
    .EDGE_MASK (EDGE_MASK),
    .NMI_CAUSE (6'd0)
  ) dut (
    .g_clk       (g_clk),
    .g_resetn    (g_resetn),
    .mstatus_mie (mstatus_mie),
    .mie_meie    (mie_meie),
    .mie_mtie    (mie_mtie),
    .mie_msie    (mie_msie),
    .ex_enable   (ex_enable),
    .nmi_pending (nmi_pending),
    .ex_pending  (ex_pending),
    .ti_pending  (ti_pending),
    .sw_pending  (sw_pending),
    .mip_meip    (mip_meip),
    .mip_mtip    (mip_mtip),
    .mip_msip    (mip_msip),
    .trap        (trap_if.master),
    .ex_claim_id (ex_claim_id)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n clock edges; inputs driven and outputs sampled 1 time unit after each edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge g_clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    trap_if.int_trap_ack = 1'b0;

    // Reset state
    #3;
    check("rst_req",   trap_if.int_trap_req, 0);
    check("rst_cause", trap_if.int_trap_cause, 0);
    check("rst_claim", ex_claim_id, 0);
    check("rst_mip",   {mip_meip, mip_mtip, mip_msip}, 0);
    cyc(2);
    g_resetn = 1'b1;
    cyc(1);

    // Input-to-request latency with the timer line
    ti_pending = 1'b1;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!trap_if.int_trap_req && n < 10);
    check("lat_cycles", n, LAT);
    check("lat_cause",  trap_if.int_trap_cause, 7);
    ti_pending = 1'b0;
    trap_if.int_trap_ack = 1'b1;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;
    cyc(LAT + 1);
    check("lat_idle", trap_if.int_trap_req, 0);

    // 1: single-cycle pulse on edge source 5
    ex_pending[5] = 1'b1;
    cyc(1);
    ex_pending[5] = 1'b0;
    check("t1_req",   trap_if.int_trap_req, 1);
    check("t1_cause", trap_if.int_trap_cause, 21);
    check("t1_meip",  mip_meip, 1);
    trap_if.int_trap_ack = 1'b1;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;
    check("t1_ack_req", trap_if.int_trap_req, 0);
    check("t1_claim",   ex_claim_id, 5);
    cyc(2);
    check("t1_noretrig", trap_if.int_trap_req, 0);
    check("t1_meip_clr", mip_meip, 0);

    // 2: level source 2 beats edge source 9 on index; 9 follows after ack
    ex_pending[2] = 1'b1;
    ex_pending[9] = 1'b1;
    cyc(1);
    check("t2_cause_a", trap_if.int_trap_cause, 18);
    trap_if.int_trap_ack = 1'b1;
    ex_pending[2] = 1'b0;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;
    check("t2_gap",    trap_if.int_trap_req, 0);
    check("t2_claim2", ex_claim_id, 2);
    cyc(1);
    check("t2_req_b",   trap_if.int_trap_req, 1);
    check("t2_cause_b", trap_if.int_trap_cause, 25);
    trap_if.int_trap_ack = 1'b1;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;
    ex_pending[9] = 1'b0;
    check("t2_claim9", ex_claim_id, 9);
    cyc(2);
    check("t2_idle", trap_if.int_trap_req, 0);

    // 3: NMI ignores MIE and is not withdrawn; software waits for MIE
    mstatus_mie = 1'b0;
    nmi_pending = 1'b1;
    sw_pending  = 1'b1;
    cyc(1);
    check("t3_req",   trap_if.int_trap_req, 1);
    check("t3_cause", trap_if.int_trap_cause, 0);
    cyc(1);
    check("t3_nmi_held", trap_if.int_trap_req, 1);
    trap_if.int_trap_ack = 1'b1;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;
    nmi_pending = 1'b0;
    cyc(2);
    check("t3_sw_masked", trap_if.int_trap_req, 0);
    check("t3_msip",      mip_msip, 1);
    mstatus_mie = 1'b1;
    cyc(1);
    check("t3_sw_req",   trap_if.int_trap_req, 1);
    check("t3_sw_cause", trap_if.int_trap_cause, 3);
    trap_if.int_trap_ack = 1'b1;
    sw_pending = 1'b0;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;

    // 4: timer request withdrawn by MIE=0, reissued by MIE=1, not withdrawn by level drop
    ti_pending = 1'b1;
    cyc(1);
    check("t4_cause", trap_if.int_trap_cause, 7);
    mstatus_mie = 1'b0;
    cyc(1);
    check("t4_withdrawn", trap_if.int_trap_req, 0);
    cyc(1);
    check("t4_stay_idle", trap_if.int_trap_req, 0);
    mstatus_mie = 1'b1;
    cyc(1);
    check("t4_req_again", trap_if.int_trap_req, 1);
    check("t4_cause2",    trap_if.int_trap_cause, 7);
    ti_pending = 1'b0;
    cyc(1);
    check("t4_level_drop_held", trap_if.int_trap_req, 1);
    trap_if.int_trap_ack = 1'b1;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;
    check("t4_ack", trap_if.int_trap_req, 0);
    check("t4_mtip", mip_mtip, 0);

    // 5: edge source re-pulses in the ack cycle
    ex_pending[5] = 1'b1;
    cyc(1);
    ex_pending[5] = 1'b0;
    check("t5_cause", trap_if.int_trap_cause, 21);
    cyc(1);
    trap_if.int_trap_ack = 1'b1;
    ex_pending[5] = 1'b1;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;
    ex_pending[5] = 1'b0;
    check("t5_gap", trap_if.int_trap_req, 0);
    cyc(1);
    check("t5_req_again", trap_if.int_trap_req, 1);
    check("t5_cause2",    trap_if.int_trap_cause, 21);
    trap_if.int_trap_ack = 1'b1;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;
    cyc(1);
    check("t5_done", trap_if.int_trap_req, 0);

    // Ack while idle is ignored
    trap_if.int_trap_ack = 1'b1;
    cyc(2);
    trap_if.int_trap_ack = 1'b0;
    check("idle_ack_req",   trap_if.int_trap_req, 0);
    check("idle_ack_claim", ex_claim_id, 5);

    // Disabled edge source keeps its latch and traps once enabled
    ex_enable[9] = 1'b0;
    ex_pending[9] = 1'b1;
    cyc(1);
    ex_pending[9] = 1'b0;
    cyc(2);
    check("dis_no_req", trap_if.int_trap_req, 0);
    ex_enable[9] = 1'b1;
    cyc(1);
    check("dis_req",   trap_if.int_trap_req, 1);
    check("dis_cause", trap_if.int_trap_cause, 25);
    trap_if.int_trap_ack = 1'b1;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;

    // NMI outranks a simultaneous external source
    nmi_pending = 1'b1;
    ex_pending[2] = 1'b1;
    cyc(1);
    check("prio_nmi", trap_if.int_trap_cause, 0);
    nmi_pending = 1'b0;
    trap_if.int_trap_ack = 1'b1;
    cyc(1);
    trap_if.int_trap_ack = 1'b0;
    cyc(1);
    check("prio_ext_next", trap_if.int_trap_cause, 18);

    // 6: asynchronous reset mid-REQ
    check("t6_in_req", trap_if.int_trap_req, 1);
    #2;
    g_resetn = 1'b0;
    #1;
    check("t6_async_req",   trap_if.int_trap_req, 0);
    check("t6_async_cause", trap_if.int_trap_cause, 0);
    check("t6_async_claim", ex_claim_id, 0);
    check("t6_async_meip",  mip_meip, 0);
    ex_pending[2] = 1'b0;
    cyc(1);
    g_resetn = 1'b1;
    cyc(2);
    check("t6_idle_after", trap_if.int_trap_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
